// File: rtl/nx_control_pkg.sv
// Command and response encodings shared by the mesh controller and its host-side initiator.
package nx_control_pkg;

    localparam int unsigned MESSAGE_WIDTH = 32;

    typedef enum logic [3:0] {
        CONTROL_COMMAND_NOP      = 4'd0,
        CONTROL_COMMAND_ACTIVE   = 4'd1,
        CONTROL_COMMAND_INTERVAL = 4'd2,
        CONTROL_COMMAND_STATUS   = 4'd3,
        CONTROL_COMMAND_CYCLES   = 4'd4
    } control_command_t;

    localparam int unsigned PAYLOAD_WIDTH = MESSAGE_WIDTH - $bits(control_command_t);

    typedef struct packed {
        control_command_t         command;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } control_message_t;

    // STATUS responses carry the active flag in bit 0; CYCLES responses use the whole word.
    typedef struct packed {
        logic [MESSAGE_WIDTH-2:0] value;
        logic                     active;
    } control_response_t;

endpackage

// File: rtl/nx_control_initiator_if.sv
// Host run request, command stream and response stream of the control initiator.
interface nx_control_initiator_if;
    import nx_control_pkg::*;

    logic [PAYLOAD_WIDTH-1:0] i_run_cycles;
    logic                     i_run_valid;
    logic                     o_run_ready;
    logic                     o_done;
    logic [MESSAGE_WIDTH-1:0] o_cycles;
    logic                     o_error;

    control_message_t         o_msg_data;
    logic                     o_msg_valid;
    logic                     i_msg_ready;

    control_response_t        i_resp_data;
    logic                     i_resp_valid;
    logic                     o_resp_ready;

    modport master (
        input  i_run_cycles,
        input  i_run_valid,
        output o_run_ready,
        output o_done,
        output o_cycles,
        output o_error,
        output o_msg_data,
        output o_msg_valid,
        input  i_msg_ready,
        input  i_resp_data,
        input  i_resp_valid,
        output o_resp_ready
    );

    modport slave (
        output i_run_cycles,
        output i_run_valid,
        input  o_run_ready,
        input  o_done,
        input  o_cycles,
        input  o_error,
        input  o_msg_data,
        input  o_msg_valid,
        output i_msg_ready,
        output i_resp_data,
        output i_resp_valid,
        input  o_resp_ready
    );

endinterface

// File: rtl/nx_control_initiator.sv
// Host-side sequencer: program interval, activate mesh, poll status, read cycle counter.
// Optional poll timeout with mesh deactivation is enabled by defining NX_CTRL_INIT_TIMEOUT_EN.
module nx_control_initiator
    import nx_control_pkg::*;
#(
    parameter int unsigned POLL_GAP      = 4,
    parameter int unsigned TIMEOUT_POLLS = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    nx_control_initiator_if.master bus
);

    localparam int unsigned POLL_CNT_W = (TIMEOUT_POLLS < 1) ? 1 : $clog2(TIMEOUT_POLLS + 1);
    localparam int unsigned GAP_W      = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [POLL_CNT_W-1:0] POLL_MAX = '1;

    localparam control_message_t ACTIVATE_MSG = '{
        command: CONTROL_COMMAND_ACTIVE,
        payload: PAYLOAD_WIDTH'(1)
    };
    localparam control_message_t STATUS_MSG = '{
        command: CONTROL_COMMAND_STATUS,
        payload: PAYLOAD_WIDTH'(0)
    };
    localparam control_message_t CYCLES_MSG = '{
        command: CONTROL_COMMAND_CYCLES,
        payload: PAYLOAD_WIDTH'(0)
    };

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INTERVAL,
        ST_ACTIVATE,
        ST_POLL,
        ST_POLL_WAIT,
        ST_GAP,
        ST_READ,
        ST_READ_WAIT,
        ST_DEACTIVATE
    } state_t;

    state_t                   state_q, state_d;
    logic                     run_ready_q, run_ready_d;
    logic                     msg_valid_q, msg_valid_d;
    control_message_t         msg_data_q, msg_data_d;
    logic                     done_q, done_d;
    logic [MESSAGE_WIDTH-1:0] cycles_q, cycles_d;
    logic                     error_q, error_d;
    logic [POLL_CNT_W-1:0]    poll_q, poll_d;
    logic [GAP_W-1:0]         gap_q, gap_d;

    logic                     xfer_c;
    logic                     run_accept_c;

    assign xfer_c       = msg_valid_q && bus.i_msg_ready;
    assign run_accept_c = run_ready_q && bus.i_run_valid;

    // State register and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            run_ready_q <= 1'b0;
            msg_valid_q <= 1'b0;
            msg_data_q  <= '0;
            done_q      <= 1'b0;
            cycles_q    <= '0;
            error_q     <= 1'b0;
            poll_q      <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            run_ready_q <= run_ready_d;
            msg_valid_q <= msg_valid_d;
            msg_data_q  <= msg_data_d;
            done_q      <= done_d;
            cycles_q    <= cycles_d;
            error_q     <= error_d;
            poll_q      <= poll_d;
            gap_q       <= gap_d;
        end
    end

    // Next-state and output decode; a command stays on the bus until it transfers.
    always_comb begin
        state_d     = state_q;
        msg_valid_d = msg_valid_q;
        msg_data_d  = msg_data_q;
        done_d      = 1'b0;
        cycles_d    = cycles_q;
        error_d     = error_q;
        poll_d      = poll_q;
        gap_d       = gap_q;

        unique case (state_q)
            ST_IDLE: begin
                if (run_accept_c) begin
                    poll_d = '0;
                    if (bus.i_run_cycles == '0) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        error_d     = 1'b0;
                        state_d     = ST_INTERVAL;
                        msg_valid_d = 1'b1;
                        msg_data_d  = '{command: CONTROL_COMMAND_INTERVAL,
                                        payload: bus.i_run_cycles};
                    end
                end
            end

            ST_INTERVAL: begin
                if (xfer_c) begin
                    state_d    = ST_ACTIVATE;
                    msg_data_d = ACTIVATE_MSG;
                end
            end

            ST_ACTIVATE: begin
                if (xfer_c) begin
                    state_d    = ST_POLL;
                    msg_data_d = STATUS_MSG;
                end
            end

            ST_POLL: begin
                if (xfer_c) begin
                    state_d     = ST_POLL_WAIT;
                    msg_valid_d = 1'b0;
                    if (poll_q != POLL_MAX) begin
                        poll_d = poll_q + POLL_CNT_W'(1);
                    end
                end
            end

            ST_POLL_WAIT: begin
                if (bus.i_resp_valid) begin
                    if (!bus.i_resp_data.active) begin
                        state_d     = ST_READ;
                        msg_valid_d = 1'b1;
                        msg_data_d  = CYCLES_MSG;
                    end
`ifdef NX_CTRL_INIT_TIMEOUT_EN
                    else if (poll_q == POLL_CNT_W'(TIMEOUT_POLLS)) begin
                        state_d     = ST_DEACTIVATE;
                        msg_valid_d = 1'b1;
                        msg_data_d  = '{command: CONTROL_COMMAND_ACTIVE,
                                        payload: PAYLOAD_WIDTH'(0)};
                    end
`endif
                    else if (POLL_GAP == 0) begin
                        state_d     = ST_POLL;
                        msg_valid_d = 1'b1;
                        msg_data_d  = STATUS_MSG;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end
                end
            end

            // Exactly POLL_GAP idle cycles before the next STATUS appears.
            ST_GAP: begin
                if (gap_q == GAP_W'(POLL_GAP - 1)) begin
                    state_d     = ST_POLL;
                    msg_valid_d = 1'b1;
                    msg_data_d  = STATUS_MSG;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            ST_READ: begin
                if (xfer_c) begin
                    state_d     = ST_READ_WAIT;
                    msg_valid_d = 1'b0;
                end
            end

            ST_READ_WAIT: begin
                if (bus.i_resp_valid) begin
                    cycles_d = bus.i_resp_data;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end

            ST_DEACTIVATE: begin
                if (xfer_c) begin
                    msg_valid_d = 1'b0;
                    error_d     = 1'b1;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                msg_valid_d = 1'b0;
            end
        endcase

        run_ready_d = (state_d == ST_IDLE);
    end

    assign bus.o_run_ready  = run_ready_q;
    assign bus.o_done       = done_q;
    assign bus.o_cycles     = cycles_q;
    assign bus.o_error      = error_q;
    assign bus.o_msg_valid  = msg_valid_q;
    assign bus.o_msg_data   = msg_data_q;
    assign bus.o_resp_ready = 1'b1;

endmodule

// File: tb/tb_nx_control_initiator.sv
// Directed bench for nx_control_initiator: run table, poll-gap, reset and timeout sequences.
module tb_nx_control_initiator;
    import nx_control_pkg::*;

    localparam int unsigned GAP0 = 4;

    logic clk;
    logic rst_n;

    nx_control_initiator_if bus0();
    nx_control_initiator_if bus1();

    nx_control_initiator #(.POLL_GAP(GAP0), .TIMEOUT_POLLS(8)) dut0 (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus0)
    );

    nx_control_initiator #(.POLL_GAP(0), .TIMEOUT_POLLS(8)) dut1 (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PAYLOAD_WIDTH-1:0] run_cycles;
        int                       stall;
        int                       active_polls;
        logic [31:0]              resp_cycles;
        int                       exp_cmds;
        int                       exp_status;
        logic [31:0]              exp_cycles;
        logic                     exp_error;
        bit                       chk_latency;
    } vec_t;

    vec_t vecs[5];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int accept_cyc = 0;

    // Controller model state (bus0)
    bit               model_en = 1'b0;
    int               stall_cfg = 0;
    int               active_cfg = 0;
    logic [31:0]      cycles_resp_cfg = '0;
    control_message_t cmd_log[$];
    int               xfer_cyc[$];
    int               gap_diff[$];
    int               stable_err = 0;
    int               status_cnt = 0;
    int               stall_cnt = 0;
    bit               in_cmd = 1'b0;
    control_message_t held;
    bit               pend = 1'b0;
    control_response_t pend_resp;
    int               last_act_cyc = -1;
    int               late_cyc = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Responds one cycle after STATUS/CYCLES transfers, optionally stalling each command.
    task automatic model_step();
        control_message_t m;
        bit xfer;
        bus0.i_resp_valid = 1'b0;
        if (cyc == late_cyc) begin
            bus0.i_resp_valid = 1'b1;
            bus0.i_resp_data  = '0;
        end else if (model_en && pend) begin
            bus0.i_resp_valid = 1'b1;
            bus0.i_resp_data  = pend_resp;
            pend = 1'b0;
            if (pend_resp.active) last_act_cyc = cyc;
        end
        m = bus0.o_msg_data;
        xfer = 1'b0;
        if (model_en && bus0.o_msg_valid) begin
            if (!in_cmd) begin
                in_cmd = 1'b1;
                held = m;
                stall_cnt = 0;
                if (m.command == CONTROL_COMMAND_STATUS && last_act_cyc >= 0) begin
                    gap_diff.push_back(cyc - last_act_cyc);
                    last_act_cyc = -1;
                end
            end else if (m !== held) begin
                stable_err++;
            end
            if (stall_cnt < stall_cfg) begin
                bus0.i_msg_ready = 1'b0;
                stall_cnt++;
            end else begin
                bus0.i_msg_ready = 1'b1;
                xfer = 1'b1;
            end
        end else begin
            bus0.i_msg_ready = 1'b0;
        end
        if (xfer) begin
            in_cmd = 1'b0;
            cmd_log.push_back(m);
            xfer_cyc.push_back(cyc);
            if (m.command == CONTROL_COMMAND_STATUS) begin
                status_cnt++;
                pend = 1'b1;
                pend_resp = '{value: '0, active: (status_cnt <= active_cfg)};
            end else if (m.command == CONTROL_COMMAND_CYCLES) begin
                pend = 1'b1;
                pend_resp = control_response_t'(cycles_resp_cfg);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus0.o_done) done_cnt++;
        model_step();
    endtask

    task automatic reset_model(input int stall, input int act, input logic [31:0] cyc_resp);
        stall_cfg = stall;
        active_cfg = act;
        cycles_resp_cfg = cyc_resp;
        cmd_log.delete();
        xfer_cyc.delete();
        gap_diff.delete();
        stable_err = 0;
        status_cnt = 0;
        stall_cnt = 0;
        in_cmd = 1'b0;
        pend = 1'b0;
        last_act_cyc = -1;
        done_cnt = 0;
        model_en = 1'b1;
    endtask

    task automatic start_run(input logic [PAYLOAD_WIDTH-1:0] rc);
        tick();
        bus0.i_run_cycles = rc;
        bus0.i_run_valid = 1'b1;
        accept_cyc = cyc;
        tick();
        bus0.i_run_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check({name, " done_seen"}, 64'(done_cnt != 0), 64'd1);
    endtask

    initial begin
        string tag;
        int n;

        vecs[0] = '{28'd10, 0, 3, 32'd10, 7, 4, 32'd10, 1'b0, 1'b1};
        vecs[1] = '{28'd0, 0, 0, 32'd0, 0, 0, 32'd10, 1'b1, 1'b0};
        vecs[2] = '{28'd10, 5, 3, 32'd10, 7, 4, 32'd10, 1'b0, 1'b0};
        vecs[3] = '{28'd7, 0, 0, 32'd1234, 4, 1, 32'd1234, 1'b0, 1'b0};
        vecs[4] = '{28'hFFF_FFFF, 2, 1, 32'hFFFF_FFFF, 5, 2, 32'hFFFF_FFFF, 1'b0, 1'b0};

        rst_n = 1'b0;
        bus0.i_run_cycles = '0;
        bus0.i_run_valid  = 1'b0;
        bus0.i_msg_ready  = 1'b0;
        bus0.i_resp_valid = 1'b0;
        bus0.i_resp_data  = '0;
        bus1.i_run_cycles = '0;
        bus1.i_run_valid  = 1'b0;
        bus1.i_msg_ready  = 1'b1;
        bus1.i_resp_valid = 1'b0;
        bus1.i_resp_data  = '0;

        tick();
        tick();
        check("reset run_ready", 64'(bus0.o_run_ready), 64'd0);
        check("reset msg_valid", 64'(bus0.o_msg_valid), 64'd0);
        check("reset msg_data", 64'(bus0.o_msg_data), 64'd0);
        check("reset done", 64'(bus0.o_done), 64'd0);
        check("reset cycles", 64'(bus0.o_cycles), 64'd0);
        check("reset error", 64'(bus0.o_error), 64'd0);
        rst_n = 1'b1;
        tick();
        check("post-reset run_ready", 64'(bus0.o_run_ready), 64'd1);
        check("resp_ready tied", 64'(bus0.o_resp_ready), 64'd1);

        for (int i = 0; i < 5; i++) begin
            tag = $sformatf("v%0d", i);
            reset_model(vecs[i].stall, vecs[i].active_polls, vecs[i].resp_cycles);
            start_run(vecs[i].run_cycles);
            wait_done(tag, 3000);
            tick();
            tick();
            tick();
            check({tag, " done pulses"}, 64'(done_cnt), 64'd1);
            check({tag, " cycles"}, 64'(bus0.o_cycles), 64'(vecs[i].exp_cycles));
            check({tag, " error"}, 64'(bus0.o_error), 64'(vecs[i].exp_error));
            check({tag, " run_ready"}, 64'(bus0.o_run_ready), 64'd1);
            check({tag, " cmd count"}, 64'(cmd_log.size()), 64'(vecs[i].exp_cmds));
            check({tag, " status count"}, 64'(status_cnt), 64'(vecs[i].exp_status));
            check({tag, " data stable"}, 64'(stable_err), 64'd0);
            if (vecs[i].exp_cmds > 0 && cmd_log.size() == vecs[i].exp_cmds) begin
                check({tag, " interval cmd"}, 64'(cmd_log[0]),
                      64'({CONTROL_COMMAND_INTERVAL, vecs[i].run_cycles}));
                check({tag, " activate cmd"}, 64'(cmd_log[1]),
                      64'({CONTROL_COMMAND_ACTIVE, 28'd1}));
                check({tag, " last cmd"}, 64'(cmd_log[vecs[i].exp_cmds-1].command),
                      64'(CONTROL_COMMAND_CYCLES));
                check({tag, " gap count"}, 64'(gap_diff.size()), 64'(vecs[i].active_polls));
                foreach (gap_diff[g])
                    check({tag, " poll gap"}, 64'(gap_diff[g]), 64'(GAP0 + 1));
            end
            if (vecs[i].chk_latency && xfer_cyc.size() >= 3) begin
                for (int k = 0; k < 3; k++)
                    check({tag, " latency"}, 64'(xfer_cyc[k] - accept_cyc), 64'(k + 1));
            end
        end

        // POLL_GAP=0: STATUS reissued the cycle after an active response.
        tick();
        bus1.i_run_cycles = 28'd3;
        bus1.i_run_valid = 1'b1;
        tick();
        bus1.i_run_valid = 1'b0;
        n = 0;
        while (!(bus1.o_msg_valid && bus1.o_msg_data.command == CONTROL_COMMAND_STATUS) && n < 20) begin
            tick();
            n++;
        end
        check("gap0 first status", 64'(bus1.o_msg_data.command), 64'(CONTROL_COMMAND_STATUS));
        tick();
        check("gap0 wait valid", 64'(bus1.o_msg_valid), 64'd0);
        bus1.i_resp_valid = 1'b1;
        bus1.i_resp_data = '{value: '0, active: 1'b1};
        tick();
        bus1.i_resp_valid = 1'b0;
        check("gap0 status next cycle", 64'({bus1.o_msg_valid, bus1.o_msg_data}),
              64'({1'b1, CONTROL_COMMAND_STATUS, 28'd0}));
        tick();
        bus1.i_resp_valid = 1'b1;
        bus1.i_resp_data = '{value: '0, active: 1'b0};
        tick();
        bus1.i_resp_valid = 1'b0;
        check("gap0 cycles cmd", 64'({bus1.o_msg_valid, bus1.o_msg_data.command}),
              64'({1'b1, CONTROL_COMMAND_CYCLES}));
        tick();
        bus1.i_resp_valid = 1'b1;
        bus1.i_resp_data = control_response_t'(32'd3);
        tick();
        bus1.i_resp_valid = 1'b0;
        check("gap0 done", 64'(bus1.o_done), 64'd1);
        check("gap0 cycles", 64'(bus1.o_cycles), 64'd3);

        // Reset while waiting on a STATUS response.
        reset_model(0, 1000000, 32'd0);
        start_run(28'd5);
        n = 0;
        while (status_cnt == 0 && n < 100) begin
            tick();
            n++;
        end
        model_en = 1'b0;
        tick();
        check("rst pre poll_wait valid", 64'(bus0.o_msg_valid), 64'd0);
        rst_n = 1'b0;
        tick();
        check("rst held valid", 64'(bus0.o_msg_valid), 64'd0);
        check("rst held run_ready", 64'(bus0.o_run_ready), 64'd0);
        tick();
        check("rst held run_ready 2", 64'(bus0.o_run_ready), 64'd0);
        rst_n = 1'b1;
        late_cyc = cyc + 1;
        done_cnt = 0;
        tick();
        check("rst release run_ready", 64'(bus0.o_run_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rst late resp ignored", 64'({bus0.o_msg_valid, bus0.o_run_ready}), 64'b01);
        end
        check("rst no done", 64'(done_cnt), 64'd0);
        reset_model(0, 2, 32'd5);
        start_run(28'd5);
        wait_done("rst rerun", 2000);
        check("rst rerun cycles", 64'(bus0.o_cycles), 64'd5);
        check("rst rerun error", 64'(bus0.o_error), 64'd0);
        check("rst rerun status", 64'(status_cnt), 64'd3);
        tick();

`ifdef NX_CTRL_INIT_TIMEOUT_EN
        reset_model(0, 1000000, 32'd0);
        start_run(28'd20);
        wait_done("timeout", 3000);
        check("timeout status count", 64'(status_cnt), 64'd8);
        check("timeout cmd count", 64'(cmd_log.size()), 64'd11);
        if (cmd_log.size() > 0)
            check("timeout deactivate", 64'(cmd_log[cmd_log.size()-1]),
                  64'({CONTROL_COMMAND_ACTIVE, 28'd0}));
        check("timeout error", 64'(bus0.o_error), 64'd1);
        check("timeout cycles kept", 64'(bus0.o_cycles), 64'd5);
`else
        reset_model(0, 1000000, 32'd0);
        start_run(28'd20);
        n = 0;
        while (status_cnt <= 100 && n < 3000) begin
            tick();
            n++;
        end
        check("no timeout polls past 100", 64'(status_cnt > 100), 64'd1);
        check("no timeout no done", 64'(done_cnt), 64'd0);
        check("no timeout error clear", 64'(bus0.o_error), 64'd0);
        model_en = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
